// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// controller states and the default operand width.
package mdu_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and either keep or restore.
module div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Trial subtraction on WIDTH+1 bits; the MSB is the borrow (negative result).
  // On restore the shifted value is below the divisor, so it fits in WIDTH bits.
  always_comb begin
    shifted  = {rem, q_msb};
    trial    = shifted - {1'b0, divisor};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential unsigned MULTU/DIVU unit owning the architectural HI/LO registers.
// Multiply is shift-add, divide is restoring; both take WIDTH iterations.
// MTHI/MTLO write HI/LO directly from IDLE in a single cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic          last_iter;

  // Multiply working set: the multiplier lives in the low half of the
  // accumulator and shifts out as the product shifts in.
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_next;

  // Divide working set: quotient register starts as the dividend and its MSB
  // feeds the remainder each step.
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (rem),
    .q_msb    (quo[WIDTH-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // One shift-add multiply step with the carry kept, plus the next quotient.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    quo_next  = {quo[WIDTH-2:0], q_bit};
    last_iter = (cnt == LAST);
  end

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: only MULTU/DIVU leave IDLE; requests while busy are dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start && op == OP_MULTU)     next_state = MUL;
        else if (start && op == OP_DIVU) next_state = DIV;
      end
      MUL:     if (last_iter) next_state = IDLE;
      DIV:     if (last_iter) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Architectural HI/LO, status flags and iteration counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            case (op)
              OP_MULTU: busy <= 1'b1;
              OP_DIVU:  busy <= 1'b1;
              OP_MTHI:  hi   <= a;
              default:  lo   <= a;
            endcase
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            hi   <= acc_next[2*WIDTH-1:WIDTH];
            lo   <= acc_next[WIDTH-1:0];
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            hi   <= rem_next;
            lo   <= quo_next;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Working operands: latched on accept, stepped each iteration; never visible.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          mcand   <= a;
          acc     <= {{WIDTH{1'b0}}, b};
          divisor <= b;
          rem     <= '0;
          quo     <= a;
        end
      end
      MUL: acc <= acc_next;
      DIV: begin
        rem <= rem_next;
        quo <= quo_next;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential unsigned multiply/divide unit holding the architectural HI/LO registers of the MIPS datapath. It runs MULTU/DIVU over WIDTH cycles using a shift-add multiplier and a restoring divider, and supports single-cycle MTHI/MTLO writes. Its `hi`/`lo` outputs feed the MFHI/MFLO lanes of the ALU result-select mux. Its `busy` output stalls the pipeline controller while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
- a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
- b  input  WIDTH  multiplier / divisor (ignored for MTHI/MTLO)
- busy  output  1  high while a MULTU/DIVU is in flight
- done  output  1  one-cycle pulse: HI/LO just took the final result
- hi  output  WIDTH  architectural HI register
- lo  output  WIDTH  architectural LO register

## Operation
- Reset (async, any state): state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0. Any in-flight operation is discarded.
- States: IDLE, MUL, DIV.
- **IDLE, start=1, op=00:** latch a and b, clear the 2·WIDTH accumulator, go to MUL.
- **IDLE, start=1, op=01:** latch a and b, clear the partial remainder, go to DIV.
- **IDLE, start=1, op=10/11:** write a to hi/lo at that edge. Stay in IDLE; no busy, no done.
- **MUL:** each cycle, if multiplier LSB=1, add the multiplicand into the upper half of the accumulator (WIDTH+1-bit add, carry kept). Then shift the accumulator and multiplier right by one.
- **DIV:** each cycle, shift {remainder, quotient} left by one. Trial-subtract the divisor (WIDTH+1 bits). If the result is non-negative, keep it and set quotient LSB=1; otherwise restore.
- **Iterations:** the counter runs 0..WIDTH-1. On the edge ending iteration WIDTH-1:
  - MULTU: hi = product[2W-1:W], lo = product[W-1:0].
  - DIVU: lo = quotient, hi = remainder.
  - done=1, busy=0, state=IDLE.
- hi and lo are never modified mid-operation; working values are internal only.
- **Divide by zero:** no special path. Full latency; result is lo = all ones, hi = a.
- **start while busy:** ignored entirely, including MTHI/MTLO. Not queued.
- **op changes during MUL/DIV:** no effect.

## Timing
- start accepted at edge E0 (state IDLE, start=1).
- busy=1 after E0 through edge E_WIDTH: exactly WIDTH cycles high.
- After edge E_WIDTH: done=1 for exactly one cycle, and hi/lo hold the final result.
- Back-to-back: start asserted during the done cycle is accepted (state is IDLE). The next result arrives WIDTH cycles later.
- MTHI/MTLO: the value is visible on hi/lo the cycle after the accepting edge.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `mdu_pkg`:
  - op encodings OP_MULTU, OP_DIVU, OP_MTHI, OP_MTLO
  - state enum {IDLE, MUL, DIV}
  - default WIDTH
- One natural sub-module, `div_step`: a combinational single restoring-division step. Inputs are remainder, quotient MSB and divisor; outputs are the new remainder and the quotient bit.
- The multiply step stays inline.
- Counter width is clog2(WIDTH).

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done exactly 32 cycles after the accept edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for 32 cycles.
- DIVU a=100, b=7 → lo=14, hi=2, done after 32 cycles. Follow with start during the done cycle, DIVU a=7, b=100 → lo=0, hi=7.
- DIVU a=0x00001234, b=0 → lo=0xFFFFFFFF, hi=0x00001234, with normal 32-cycle latency.
- MULTU 3×5 in flight; at cycle 10 assert start with op=MTHI, a=0xDEAD → ignored; final hi=0, lo=15; done pulses once.
- Reset asserted asynchronously mid-clock at cycle 16 of a DIVU → busy, done, hi, lo are 0 immediately. After release, the next MULTU 2×3 gives lo=6 in 32 cycles.
- MTHI a=0xAAAA5555, then next cycle MTLO a=0x12345678 → hi and lo update one edge each; busy and done stay 0.
